ov7670_config_sequencer: RTL
============================

Name: ov7670_config_sequencer

Overview:
- Walks the OV7670 register configuration ROM from address 0 upward and issues one SCCB register write per entry through a valid/ready request port to the SCCB master.
- Inserts a long settle delay after a COM7 soft-reset write and a short delay after every other write.
- Stops at the end-of-ROM marker 0xFFFF, or after entry 255.
- Sits between the config ROM (upstream, 1-cycle synchronous read) and the SCCB master (downstream).

Parameters:
- RESET_DELAY_CYCLES, 1_000_000, idle cycles after a COM7 soft-reset write (≈10 ms at 100 MHz).
- WRITE_DELAY_CYCLES, 1_000, idle cycles after any other write.
- DEV_ADDR, 8'h42, SCCB write address of the camera.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  single-cycle start pulse
- rom_addr_o  out  8  ROM read address (registered)
- rom_data_i  in  16  ROM data; [15:8] register, [7:0] value; valid one cycle after rom_addr_o is presented
- sccb_valid_o  out  1  write request valid
- sccb_ready_i  in  1  SCCB master accepts request
- sccb_done_i  in  1  one-cycle pulse, transaction finished on the bus
- sccb_dev_addr_o  out  8  device address
- sccb_reg_addr_o  out  8  register address
- sccb_reg_data_o  out  8  register value
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence complete (level, held)
- write_count_o  out  8  number of writes completed this run

Behaviour:
- Reset (async, takes effect immediately):
  - State IDLE; rom_addr_o = 0; sccb_valid_o = 0.
  - sccb_reg_addr_o = 0; sccb_reg_data_o = 0; sccb_dev_addr_o = DEV_ADDR.
  - busy_o = 0; done_o = 0; write_count_o = 0; delay counter = 0.
- Reset mid-operation aborts the sequence. The SCCB master shares rst_i, so no half-issued request survives.
- IDLE:
  - On start_i: rom_addr_o <= 0, write_count_o <= 0, done_o <= 0 → FETCH.
  - busy_o = 1 in every state except IDLE and DONE.
- FETCH: exactly one cycle, lets the ROM register the addressed word → DECODE.
- DECODE: rom_data_i is valid this cycle.
  - If rom_data_i == 16'hFFFF → DONE.
  - Else latch sccb_reg_addr_o <= [15:8] and sccb_reg_data_o <= [7:0].
  - Set is_reset flag = (reg == 8'h12 && value[7]) → SEND.
- SEND:
  - sccb_valid_o = 1, with address and data stable.
  - Transfer occurs on the cycle where valid && ready → WAIT_DONE; valid drops the following cycle.
  - Valid must never drop before ready.
- WAIT_DONE:
  - On sccb_done_i: write_count_o increments (saturating at 255).
  - Load delay counter with RESET_DELAY_CYCLES if is_reset, else WRITE_DELAY_CYCLES → DELAY.
  - A sccb_done_i in any other state is ignored.
- DELAY:
  - If counter == 0: if rom_addr_o == 255 → DONE, else rom_addr_o <= rom_addr_o + 1 → FETCH.
  - Else decrement.
  - DELAY occupies N+1 cycles for a loaded value N.
  - The counter is 32 bits and must hold both parameters.
- DONE:
  - done_o = 1 and busy_o = 0, held.
  - A start_i pulse restarts exactly as from IDLE.
- start_i is ignored while busy_o = 1.
- Address wrap: entry 255 is the last one fetched; the address never wraps to 0.
- Throughput per entry: 1 FETCH + 1 DECODE + SEND wait + bus time + (N+1) delay.

Decomposition:
- Package ov7670_pkg:
  - Typedef seq_state_t {IDLE, FETCH, DECODE, SEND, WAIT_DONE, DELAY, DONE}.
  - Constants OV7670_WRITE_ADDR = 8'h42, CONFIG_END_MARKER = 16'hFFFF, REG_COM7 = 8'h12, COM7_RESET_BIT = 7.
- No sub-module is needed; a single FSM plus counter suffices.
- The SCCB master is a separate block, connected to this one at top level.

Test Plan (bench ROM model with 1-cycle read latency; RESET_DELAY_CYCLES = 20, WRITE_DELAY_CYCLES = 4; SCCB model asserts ready 2 cycles after valid and done 10 cycles after accept):
- ROM {0x1280, 0x1204, 0xFFFF}, start_i pulse → writes (0x12,0x80), then (0x12,0x04).
  - Gap from first done to second valid = 21 + 2 cycles.
  - done_o rises; write_count_o = 2; busy_o falls in the same cycle done_o rises.
- ROM {0x1100, 0x3A04, 0xFFFF} → gap between writes = 5 + 2 cycles.
  - sccb_dev_addr_o = 0x42 throughout; valid held stable with unchanged data until ready.
- ROM word 0 = 0xFFFF → no sccb_valid_o ever; done_o = 1 three cycles after start; write_count_o = 0.
- ROM with no marker (256 entries of 0x1100) → exactly 256 writes; last rom_addr_o = 255; done_o = 1, no wrap.
- Assert rst_i during WAIT_DONE of entry 3 → all outputs return to reset values immediately.
  - A new start_i re-fetches address 0.
- start_i pulses while busy → ignored, sequence unaffected.
  - start_i in DONE → restart; write_count_o clears to 0.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_DONE,
    DELAY,
    DONE
  } seq_state_t;

  localparam logic [7:0]  OV7670_WRITE_ADDR = 8'h42;
  localparam logic [15:0] CONFIG_END_MARKER = 16'hFFFF;
  localparam logic [7:0]  REG_COM7          = 8'h12;
  localparam int          COM7_RESET_BIT    = 7;

endpackage

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB register write per entry,
// pausing after each write (long pause after a COM7 soft reset).
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned RESET_DELAY_CYCLES = 1_000_000,
  parameter int unsigned WRITE_DELAY_CYCLES = 1_000,
  parameter logic [7:0]  DEV_ADDR           = OV7670_WRITE_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        sccb_valid_o,
  input  logic        sccb_ready_i,
  input  logic        sccb_done_i,
  output logic [7:0]  sccb_dev_addr_o,
  output logic [7:0]  sccb_reg_addr_o,
  output logic [7:0]  sccb_reg_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  write_count_o
);

  seq_state_t  state_reg, state_next;
  logic [7:0]  rom_addr_reg, rom_addr_next;
  logic [7:0]  reg_addr_reg, reg_addr_next;
  logic [7:0]  reg_data_reg, reg_data_next;
  logic        is_reset_reg, is_reset_next;
  logic [31:0] delay_reg, delay_next;
  logic [7:0]  count_reg, count_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      rom_addr_reg <= 8'd0;
      reg_addr_reg <= 8'd0;
      reg_data_reg <= 8'd0;
      is_reset_reg <= 1'b0;
      delay_reg    <= 32'd0;
      count_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      reg_addr_reg <= reg_addr_next;
      reg_data_reg <= reg_data_next;
      is_reset_reg <= is_reset_next;
      delay_reg    <= delay_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    reg_addr_next = reg_addr_reg;
    reg_data_next = reg_data_reg;
    is_reset_next = is_reset_reg;
    delay_next    = delay_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          rom_addr_next = 8'd0;
          count_next    = 8'd0;
          state_next    = FETCH;
        end
      end
      FETCH: state_next = DECODE;
      DECODE: begin
        if (rom_data_i == CONFIG_END_MARKER) begin
          state_next = DONE;
        end else begin
          reg_addr_next = rom_data_i[15:8];
          reg_data_next = rom_data_i[7:0];
          is_reset_next = (rom_data_i[15:8] == REG_COM7) && rom_data_i[COM7_RESET_BIT];
          state_next    = SEND;
        end
      end
      SEND: begin
        if (sccb_ready_i) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sccb_done_i) begin
          if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
          delay_next = is_reset_reg ? RESET_DELAY_CYCLES : WRITE_DELAY_CYCLES;
          state_next = DELAY;
        end
      end
      DELAY: begin
        if (delay_reg == 32'd0) begin
          // Entry 255 is the last one; the address never wraps back to 0.
          if (rom_addr_reg == 8'hFF) begin
            state_next = DONE;
          end else begin
            rom_addr_next = rom_addr_reg + 8'd1;
            state_next    = FETCH;
          end
        end else begin
          delay_next = delay_reg - 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_addr_o      = rom_addr_reg;
  assign sccb_valid_o    = (state_reg == SEND);
  assign sccb_dev_addr_o = DEV_ADDR;
  assign sccb_reg_addr_o = reg_addr_reg;
  assign sccb_reg_data_o = reg_data_reg;
  assign busy_o          = (state_reg != IDLE) && (state_reg != DONE);
  assign done_o          = (state_reg == DONE);
  assign write_count_o   = count_reg;

endmodule
